// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter: FSM state codes and
// transaction owner codes.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_I = 2'd1;
    localparam logic [1:0] ST_WAIT_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard: counts data grants given while a fetch waits and flags
// when the limit is reached. Only built with ARB_FETCH_STARVE_GUARD_EN.
`ifdef ARB_FETCH_STARVE_GUARD_EN
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic grant_d,
    input  logic grant_i,
    input  logic if_req,
    output logic starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Saturates at the limit so a long data burst cannot wrap it back to zero.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starved = (starve_cnt == LIMIT);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Optional fetch starvation guard: define ARB_FETCH_STARVE_GUARD_EN.
//
// state   | meaning
// IDLE    | no access in flight; pick data first, else fetch
// WAIT_I  | fetch issued, mem_* held until mem_ready
// WAIT_D  | load/store issued, mem_* held until mem_ready
// RESP    | owner's ack registered for the following cycle; requests ignored
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    logic [1:0] state;
    owner_t     owner;
    logic       fetch_first;
    logic       grant_d;
    logic       grant_i;

`ifdef ARB_FETCH_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .Clock   (Clock),
        .Reset   (Reset),
        .grant_d (grant_d),
        .grant_i (grant_i),
        .if_req  (if_req),
        .starved (fetch_first)
    );
`else
    // Strict data priority; only a nonsensical negative limit could flip it.
    assign fetch_first = (STARVE_LIMIT < 0);
`endif

    // MEM holds the older instruction, so data wins unless fetch is starved.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == ST_IDLE) begin
            if (if_req && fetch_first) begin
                grant_i = 1'b1;
            end else if (dm_req) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        owner     <= OWN_D;
                        state     <= ST_WAIT_D;
                    end else if (grant_i) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        owner    <= OWN_I;
                        state    <= ST_WAIT_I;
                    end
                end
                ST_WAIT_I, ST_WAIT_D: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        // Stores capture too; the value is simply unused.
                        if (state == ST_WAIT_I) begin
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_rdata <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if_ack <= (owner == OWN_I);
                    dm_ack <= (owner == OWN_D);
                    owner  <= OWN_NONE;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          dm_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] last_if_rdata = '0;
    logic [DW-1:0] last_dm_rdata = '0;

    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic [DW-1:0] shadow    [logic [AW-1:0]];

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waitn;
        logic          exp_we;
        logic [DW-1:0] exp_rdata;
        int            exp_ack_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_val(a);
    endfunction

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    // One isolated access from IDLE; cycle 0 is the cycle the request is presented.
    task automatic run_vec(input vec_t v);
        logic exp_iack;
        logic exp_dack;
        if_req   = !v.is_d;
        if_addr  = v.addr;
        dm_req   = v.is_d;
        dm_we    = v.we;
        dm_addr  = v.addr;
        dm_wdata = v.wdata;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        settle();
        check("vec_stall_c0", v.is_d ? dm_stall : if_stall, 1);
        for (int cyc = 1; cyc <= v.exp_ack_cyc + 1; cyc++) begin
            tick();
            exp_iack = (cyc == v.exp_ack_cyc) && !v.is_d;
            exp_dack = (cyc == v.exp_ack_cyc) && v.is_d;
            check("vec_mem_req", mem_req, (cyc <= v.waitn + 1));
            if (cyc <= v.waitn + 1) begin
                check("vec_mem_addr", mem_addr, v.addr);
                check("vec_mem_we", mem_we, v.exp_we);
                if (v.is_d) check("vec_mem_wdata", mem_wdata, v.wdata);
            end
            check("vec_if_ack", if_ack, exp_iack);
            check("vec_dm_ack", dm_ack, exp_dack);
            if (cyc == v.exp_ack_cyc) begin
                if (v.is_d) begin
                    check("vec_dm_rdata", dm_rdata, v.exp_rdata);
                    check("vec_if_rdata_hold", if_rdata, last_if_rdata);
                    last_dm_rdata = v.exp_rdata;
                end else begin
                    check("vec_if_rdata", if_rdata, v.exp_rdata);
                    check("vec_dm_rdata_hold", dm_rdata, last_dm_rdata);
                    last_if_rdata = v.exp_rdata;
                end
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            mem_ready = (cyc == v.waitn + 1);
            mem_rdata = mem_ready ? v.rdata : $urandom;
            settle();
            check("vec_stall", v.is_d ? dm_stall : if_stall, (cyc < v.exp_ack_cyc));
        end
        mem_ready = 1'b0;
    endtask

    task automatic random_phase(input int ncyc);
        bit            i_pend = 0, d_pend = 0, d_w = 0;
        logic [AW-1:0] i_a = '0, d_a = '0;
        logic [DW-1:0] d_wd = '0;
        bit            p_ireq = 0, p_dreq = 0, p_dwe = 0;
        logic [AW-1:0] p_iaddr = '0, p_daddr = '0;
        logic [DW-1:0] p_dwd = '0;
        bit            p_mreq = 0, p_ready = 0, p_mwe = 0;
        logic [AW-1:0] p_maddr = '0;
        logic [DW-1:0] p_mwd = '0;
        int            owner = 0;
        int            due = -1;
        int            due_owner = 0;
        bit            cand_d, cand_i, stop, exp_iack, exp_dack;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            tick();
            stop = (cyc >= ncyc - 30);
            if (p_mreq && p_ready) begin
                if (p_mwe) mem_model[p_maddr] = p_mwd;
                due = cyc + 1;
                due_owner = owner;
            end
            if (mem_req && !p_mreq) begin
                cand_d = p_dreq && (mem_we === p_dwe) && (mem_addr === p_daddr) && (!p_dwe || (mem_wdata === p_dwd));
                cand_i = p_ireq && (mem_we === 1'b0) && (mem_addr === p_iaddr);
`ifdef ARB_FETCH_STARVE_GUARD_EN
                check("rand_issue", cand_d | cand_i, 1);
                owner = cand_d ? 2 : 1;
`else
                if (p_dreq) begin
                    check("rand_issue_data_first", cand_d, 1);
                    owner = 2;
                end else begin
                    check("rand_issue_fetch", cand_i, 1);
                    owner = 1;
                end
`endif
            end
            if (mem_req && p_mreq) begin
                check("rand_addr_stable", mem_addr, p_maddr);
                check("rand_we_stable", mem_we, p_mwe);
                check("rand_wdata_stable", mem_wdata, p_mwd);
            end
            exp_iack = (due == cyc) && (due_owner == 1);
            exp_dack = (due == cyc) && (due_owner == 2);
            check("rand_if_ack", if_ack, exp_iack);
            check("rand_dm_ack", dm_ack, exp_dack);
            if (due == cyc) begin
                if (due_owner == 1) begin
                    check("rand_if_rdata", if_rdata, shadow_rd(i_a));
                    i_pend = 0;
                end else begin
                    if (d_w) shadow[d_a] = d_wd;
                    else check("rand_dm_rdata", dm_rdata, shadow_rd(d_a));
                    d_pend = 0;
                end
                due = -1;
            end
            if (!i_pend && !stop && ($urandom_range(1, 0) == 1)) begin
                i_pend = 1;
                i_a = 32'h100 + 4 * $urandom_range(7, 0);
            end
            if (!d_pend && !stop && ($urandom_range(1, 0) == 1)) begin
                d_pend = 1;
                d_w  = ($urandom_range(1, 0) == 1);
                d_a  = 32'h200 + 4 * $urandom_range(7, 0);
                d_wd = $urandom;
            end
            if_req    = i_pend;
            if_addr   = i_pend ? i_a : $urandom;
            dm_req    = d_pend;
            dm_we     = d_w;
            dm_addr   = d_pend ? d_a : $urandom;
            dm_wdata  = d_wd;
            mem_ready = stop ? 1'b1 : ($urandom_range(1, 0) == 1);
            mem_rdata = mem_rd(mem_addr);
            settle();
            check("rand_if_stall", if_stall, i_pend & ~exp_iack);
            check("rand_dm_stall", dm_stall, d_pend & ~exp_dack);
            p_ireq = i_pend; p_iaddr = if_addr;
            p_dreq = d_pend; p_daddr = dm_addr; p_dwe = d_w; p_dwd = d_wd;
            p_mreq = mem_req; p_maddr = mem_addr; p_mwe = mem_we; p_mwd = mem_wdata;
            p_ready = mem_ready;
        end
        check("rand_drained", {30'd0, i_pend, d_pend}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr;
        bit prev_mreq;
        bit got_i, exp_i;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h2008_0005, 0, 1'b0, 32'h2008_0005, 3};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0000_1234, 5, 1'b0, 32'h0000_1234, 8};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h0000_0055, 1, 1'b1, 32'h0000_0055, 4};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 2, 1'b0, 32'hFFFF_FFFF, 5};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0001, 0, 1'b0, 32'hA5A5_0001, 3};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0, 32'h0000_0013, 3, 1'b0, 32'h0000_0013, 6};

        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_if_ack", if_ack, 0);
        check("reset_dm_ack", dm_ack, 0);
        check("reset_if_rdata", if_rdata, 0);
        check("reset_dm_rdata", dm_rdata, 0);
        Reset = 1'b0;
        tick();

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset in the middle of a stalled load.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_ready = 1'b0;
        tick();
        check("rst_issue", mem_req, 1);
        tick();
        Reset = 1'b1;
        #1;
        check("rst_mem_req_async", mem_req, 0);
        check("rst_mem_addr_async", mem_addr, 0);
        check("rst_dm_ack", dm_ack, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_hold_mem_req", mem_req, 0);
            check("rst_hold_dm_ack", dm_ack, 0);
            check("rst_hold_if_ack", if_ack, 0);
        end
        dm_req = 1'b0;
        Reset = 1'b0;
        last_if_rdata = '0;
        last_dm_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_after_mem_req", mem_req, 0);
            check("rst_after_dm_ack", dm_ack, 0);
            check("rst_after_if_ack", if_ack, 0);
        end
        check("rst_dm_rdata_clr", dm_rdata, 0);
        if_req = 1'b1; if_addr = 32'h34;
        tick();
        check("rst_idle_issue", mem_req, 1);
        check("rst_idle_addr", mem_addr, 32'h34);
        mem_ready = 1'b1; mem_rdata = 32'h99;
        tick();
        check("rst_resp_mem_req", mem_req, 0);
        mem_ready = 1'b0;
        tick();
        check("rst_if_ack", if_ack, 1);
        check("rst_if_rdata", if_rdata, 32'h99);
        if_req = 1'b0;
        last_if_rdata = 32'h99;
        tick();
        check("rst_if_ack_pulse", if_ack, 0);

        // Simultaneous store and fetch: the store goes first.
        if_req = 1'b1; if_addr = 32'h50;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        settle();
        check("both_if_stall_c0", if_stall, 1);
        tick();
        check("both_d_req", mem_req, 1);
        check("both_d_we", mem_we, 1);
        check("both_d_addr", mem_addr, 32'h40);
        check("both_d_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("both_resp_mem_req", mem_req, 0);
        tick();
        check("both_dm_ack", dm_ack, 1);
        check("both_if_ack_low", if_ack, 0);
        check("both_if_stall", if_stall, 1);
        dm_req = 1'b0;
        tick();
        check("both_i_req", mem_req, 1);
        check("both_i_we", mem_we, 0);
        check("both_i_addr", mem_addr, 32'h50);
        tick();
        tick();
        check("both_if_ack", if_ack, 1);
        check("both_if_rdata", if_rdata, 32'h0BAD_F00D);
        if_req = 1'b0;
        mem_ready = 1'b0;
        settle();
        check("both_if_stall_end", if_stall, 0);
        tick();
        check("both_idle", mem_req, 0);

        // Fetch withdrawn while waiting on memory.
        if_req = 1'b1; if_addr = 32'h60;
        tick();
        check("wd_issue", mem_req, 1);
        tick();
        if_req = 1'b0;
        settle();
        check("wd_stall_low", if_stall, 0);
        check("wd_still_waiting", mem_req, 1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ready = 1'b0;
        check("wd_resp_no_ack", if_ack, 0);
        tick();
        check("wd_if_ack", if_ack, 1);
        check("wd_if_rdata", if_rdata, 32'h77);
        last_if_rdata = 32'h77;
        tick();
        check("wd_ack_once", if_ack, 0);
        check("wd_back_idle", mem_req, 0);
        tick();
        check("wd_no_reissue", mem_req, 0);

        // Both requesters held high: grant order.
        if_req = 1'b1; if_addr = 32'h70;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h90;
        mem_ready = 1'b1; mem_rdata = 32'h5;
        ngr = 0;
        prev_mreq = 1'b0;
        for (int k = 0; k < 40 && ngr < 6; k++) begin
            tick();
            if (mem_req && !prev_mreq) begin
                got_i = (mem_addr == 32'h70);
`ifdef ARB_FETCH_STARVE_GUARD_EN
                exp_i = (((ngr + 1) % (LIMIT + 1)) == 0);
`else
                exp_i = 1'b0;
`endif
                check("grant_order", got_i, exp_i);
                ngr++;
            end
            prev_mreq = mem_req;
        end
        check("grant_count", ngr, 6);
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        mem_ready = 1'b0;

        random_phase(700);

        idle_inputs();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
